hazard_ctrl: RTL and testbench
==============================

# hazard_ctrl

Pipeline hazard and stall controller for the five-stage MIPS-C3 core, the successor to the combinational instruction-class decoder. It classifies the D-stage instruction into source registers and use times, and tracks destination and result-ready times for the instructions in E and M. It also runs a parametrised multiply/divide busy counter. Its registered state advances with the pipeline, and it drives a single `stall` that freezes F/D and inserts a bubble into E.

## Interface
- `MULT_CYCLES`, default 5: busy cycles after mult/multu issues; range 1..2^CNT_W-1.
- `DIV_CYCLES`, default 10: busy cycles after div/divu issues; range 1..2^CNT_W-1.
- `CNT_W`, default 4: width of the busy counter.
- `clk` in 1: single clock; all state updates on the rising edge.
- `rst_n` in 1: asynchronous, active-low reset.
- `instr_d` in 32: instruction currently in D.
- `valid_d` in 1: `instr_d` is a real instruction; when 0 it is treated as a nop.
- `stall` out 1: combinational; hold F/D and bubble E.
- `stall_cause` out 2: combinational; 0 none, 1 data hazard, 2 md busy (data has priority).
- `md_busy` out 1: registered; busy counter ≠ 0.
- `e_dest`, `m_dest` out 5 each: destination register of the E / M instruction; 0 means none.
- `e_tnew`, `m_tnew` out 2 each: cycles until that stage's result is forwardable.

## Operation
- **Decode of D**, by opcode, funct and rt exactly as the core ISA defines them:
  - Unknown opcodes and nop (`instr_d == 0` or `!valid_d`) have no sources and no destination.
- **Sources and Tuse:**
  - Branches (beq, bne, blez, bgtz, bltz, bgez) and jr/jalr: rs and rt, Tuse 0. blez, bgtz, bltz and bgez read rs only.
  - R-R ALU: rs and rt, Tuse 1.
  - mult, multu, div, divu: rs and rt, Tuse 1.
  - mthi/mtlo: rs, Tuse 1.
  - R-I: rs, Tuse 1. lui has no source.
  - Load: rs, Tuse 1.
  - Store: rs Tuse 1, rt Tuse 2.
  - mfhi/mflo: no GPR source.
- **Destination and Tnew at entry to E:**
  - R-R ALU, mfhi, mflo: rd, Tnew 1.
  - jalr: rd, Tnew 0.
  - R-I: rt, Tnew 1.
  - Load: rt, Tnew 2.
  - jal: 31, Tnew 0.
  - All others: dest 0, Tnew 0.
- **Data hazard:** for each source s with register r ≠ 0, a hazard exists if (r == `e_dest` && `e_tnew` > Tuse_s) or (r == `m_dest` && `m_tnew` > Tuse_s).
  - W-stage writes are forwarded through the register file, so W is never checked.
- **MD hazard:** D holds mult, multu, div, divu, mthi, mtlo, mfhi or mflo, and `md_busy` == 1.
- `stall` is the data hazard OR the MD hazard.
- **Pipeline registers, each edge:**
  - M ← E, with `m_tnew` = max(`e_tnew` − 1, 0).
  - E ← decoded D, or dest 0 / Tnew 0 when `stall` is 1.
- **Busy counter:**
  - Loads `MULT_CYCLES` (mult/multu) or `DIV_CYCLES` (div/divu) on an edge where that instruction is in D, `valid_d` is 1 and `stall` is 0.
  - Otherwise it decrements while nonzero and saturates at 0.
  - mthi/mtlo never load the counter.

## Timing
- **Reset (`rst_n` low, asynchronous):**
  - `e_dest`, `e_tnew`, `m_dest`, `m_tnew`, the counter and `md_busy` go to 0.
  - `stall` and `stall_cause` go to 0, given `instr_d` = 0.
- Reset asserted mid-operation clears the busy count immediately. The first edge after release behaves as if E and M hold nops.
- `stall` and `stall_cause` depend on `instr_d`, `valid_d` and registered state only, with no path from `stall` to itself. The registered state does not change during a stall except for the E bubble and the M shift.
- mult issued at edge t: `md_busy` is high after t for exactly `MULT_CYCLES` cycles.
- An MD-class instruction held in D issues on the first edge where `md_busy` is 0.
- A load followed by a dependent R-R ALU instruction stalls 1 cycle. A load followed by a dependent branch stalls 2 cycles. An R-R ALU or R-I instruction followed by a dependent branch stalls 1 cycle.
- A load followed by a store whose rt is the load destination does not stall.

## Test plan
- Load-use: `lw $2,0($1)` then `addu $3,$2,$4`:
  - `stall` = 1 with cause 1 for exactly one cycle.
  - `e_dest` = 0 during the bubble; then `m_dest` = 2, `m_tnew` = 1 and the add issues.
- Branch after ALU: `addu $5,$6,$7` then `beq $5,$0,x` stalls 1 cycle. `lw $5` then `beq $5,$0,x` stalls 2 cycles.
- jal/jr and $0:
  - `jal` then `jr $31`: no stall (Tnew 0).
  - `lw $0,0($1)` then `addu $3,$0,$0`: no stall.
  - `lw $8` then `sw $8,0($9)`: no stall.
- MD busy with defaults: `mult $1,$2` then `mflo $3`:
  - `md_busy` is 1 for 5 cycles; `stall` = 1 with cause 2 for 5 cycles.
  - `mflo` issues on the 6th edge. The same with `div` gives 10 cycles, and `mthi` after `mult` also waits.
- Reset mid-operation: drop `rst_n` 3 cycles into a `div` busy window.
  - All outputs are 0 immediately.
  - After release, `mfhi` issues with no stall.
- Parameter sweep: `MULT_CYCLES`=1 and `DIV_CYCLES`=15 with `CNT_W`=4 give exactly 1 and 15 busy cycles.

Source files
------------

// File: rtl/hazard_ctrl.sv
// Hazard and stall controller for the five-stage MIPS-C3 pipeline.
// Decodes D, tracks E/M result timing and the mult/div busy window.
module hazard_ctrl #(
  parameter int MULT_CYCLES = 5,
  parameter int DIV_CYCLES  = 10,
  parameter int CNT_W       = 4
) (
  input  logic        clk,
  input  logic        rst_n,
  input  logic [31:0] instr_d,
  input  logic        valid_d,
  output logic        stall,
  output logic [1:0]  stall_cause,
  output logic        md_busy,
  output logic [4:0]  e_dest,
  output logic [4:0]  m_dest,
  output logic [1:0]  e_tnew,
  output logic [1:0]  m_tnew
);

  localparam logic [5:0] OP_SPECIAL = 6'h00, OP_REGIMM = 6'h01, OP_JAL  = 6'h03;
  localparam logic [5:0] OP_BEQ  = 6'h04, OP_BNE  = 6'h05, OP_BLEZ = 6'h06, OP_BGTZ = 6'h07;
  localparam logic [5:0] OP_ADDI = 6'h08, OP_ADDIU = 6'h09, OP_SLTI = 6'h0a, OP_SLTIU = 6'h0b;
  localparam logic [5:0] OP_ANDI = 6'h0c, OP_ORI  = 6'h0d, OP_XORI = 6'h0e, OP_LUI  = 6'h0f;
  localparam logic [5:0] OP_LB = 6'h20, OP_LH = 6'h21, OP_LW = 6'h23, OP_LBU = 6'h24, OP_LHU = 6'h25;
  localparam logic [5:0] OP_SB = 6'h28, OP_SH = 6'h29, OP_SW = 6'h2b;

  localparam logic [5:0] F_SLL = 6'h00, F_SRL = 6'h02, F_SRA = 6'h03, F_SLLV = 6'h04;
  localparam logic [5:0] F_SRLV = 6'h06, F_SRAV = 6'h07, F_JR = 6'h08, F_JALR = 6'h09;
  localparam logic [5:0] F_MFHI = 6'h10, F_MTHI = 6'h11, F_MFLO = 6'h12, F_MTLO = 6'h13;
  localparam logic [5:0] F_MULT = 6'h18, F_MULTU = 6'h19, F_DIV = 6'h1a, F_DIVU = 6'h1b;
  localparam logic [5:0] F_ADD = 6'h20, F_ADDU = 6'h21, F_SUB = 6'h22, F_SUBU = 6'h23;
  localparam logic [5:0] F_AND = 6'h24, F_OR = 6'h25, F_XOR = 6'h26, F_NOR = 6'h27;
  localparam logic [5:0] F_SLT = 6'h2a, F_SLTU = 6'h2b;

  localparam logic [4:0] RT_BLTZ = 5'h00, RT_BGEZ = 5'h01;

  localparam logic [CNT_W-1:0] MULT_LOAD = CNT_W'(MULT_CYCLES);
  localparam logic [CNT_W-1:0] DIV_LOAD  = CNT_W'(DIV_CYCLES);
  localparam logic [CNT_W-1:0] CNT_ONE   = CNT_W'(1);

  logic [5:0] opcode, funct;
  logic [4:0] rs, rt, rd;
  logic [4:0] src_a, src_b, d_dest;
  logic [1:0] use_a, use_b, d_tnew;
  logic       d_md, d_mult, d_div;
  logic       haz_a, haz_b, data_hazard, md_hazard;
  logic [CNT_W-1:0] md_cnt;

  assign opcode = instr_d[31:26];
  assign rs     = instr_d[25:21];
  assign rt     = instr_d[20:16];
  assign rd     = instr_d[15:11];
  assign funct  = instr_d[5:0];

  // Classify D into its source registers with use times and its destination with Tnew.
  always_comb begin
    src_a  = '0;
    src_b  = '0;
    use_a  = '0;
    use_b  = '0;
    d_dest = '0;
    d_tnew = '0;
    d_md   = 1'b0;
    d_mult = 1'b0;
    d_div  = 1'b0;
    if (valid_d && instr_d != 32'd0) begin
      case (opcode)
        OP_SPECIAL: begin
          case (funct)
            F_SLL, F_SRL, F_SRA, F_SLLV, F_SRLV, F_SRAV,
            F_ADD, F_ADDU, F_SUB, F_SUBU, F_AND, F_OR, F_XOR, F_NOR, F_SLT, F_SLTU: begin
              src_a = rs; use_a = 2'd1; src_b = rt; use_b = 2'd1;
              d_dest = rd; d_tnew = 2'd1;
            end
            F_JR: begin
              src_a = rs; src_b = rt;
            end
            F_JALR: begin
              src_a = rs; src_b = rt; d_dest = rd;
            end
            F_MFHI, F_MFLO: begin
              d_dest = rd; d_tnew = 2'd1; d_md = 1'b1;
            end
            F_MTHI, F_MTLO: begin
              src_a = rs; use_a = 2'd1; d_md = 1'b1;
            end
            F_MULT, F_MULTU: begin
              src_a = rs; use_a = 2'd1; src_b = rt; use_b = 2'd1;
              d_md = 1'b1; d_mult = 1'b1;
            end
            F_DIV, F_DIVU: begin
              src_a = rs; use_a = 2'd1; src_b = rt; use_b = 2'd1;
              d_md = 1'b1; d_div = 1'b1;
            end
            default: ;
          endcase
        end
        OP_REGIMM: begin
          if (rt == RT_BLTZ || rt == RT_BGEZ) src_a = rs;
        end
        OP_BEQ, OP_BNE: begin
          src_a = rs; src_b = rt;
        end
        OP_BLEZ, OP_BGTZ: src_a = rs;
        OP_JAL: d_dest = 5'd31;
        OP_ADDI, OP_ADDIU, OP_SLTI, OP_SLTIU, OP_ANDI, OP_ORI, OP_XORI: begin
          src_a = rs; use_a = 2'd1; d_dest = rt; d_tnew = 2'd1;
        end
        OP_LUI: begin
          d_dest = rt; d_tnew = 2'd1;
        end
        OP_LB, OP_LH, OP_LW, OP_LBU, OP_LHU: begin
          src_a = rs; use_a = 2'd1; d_dest = rt; d_tnew = 2'd2;
        end
        OP_SB, OP_SH, OP_SW: begin
          src_a = rs; use_a = 2'd1; src_b = rt; use_b = 2'd2;
        end
        default: ;
      endcase
    end
  end

  // W is covered by register-file write-through, so only E and M can block a source.
  assign haz_a = (src_a != 5'd0) &&
                 ((src_a == e_dest && e_tnew > use_a) || (src_a == m_dest && m_tnew > use_a));
  assign haz_b = (src_b != 5'd0) &&
                 ((src_b == e_dest && e_tnew > use_b) || (src_b == m_dest && m_tnew > use_b));
  assign data_hazard = haz_a | haz_b;
  assign md_hazard   = d_md & md_busy;
  assign md_busy     = (md_cnt != '0);

  always_comb begin
    stall       = data_hazard | md_hazard;
    stall_cause = 2'd0;
    if (data_hazard)    stall_cause = 2'd1;
    else if (md_hazard) stall_cause = 2'd2;
  end

  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      e_dest <= '0;
      e_tnew <= '0;
      m_dest <= '0;
      m_tnew <= '0;
    end else begin
      m_dest <= e_dest;
      m_tnew <= (e_tnew == 2'd0) ? 2'd0 : e_tnew - 2'd1;
      e_dest <= stall ? 5'd0 : d_dest;
      e_tnew <= stall ? 2'd0 : d_tnew;
    end
  end

  // A mult/div can only reach here with the counter already idle, since it stalls while busy.
  always_ff @(posedge clk or negedge rst_n) begin
    if (!rst_n) begin
      md_cnt <= '0;
    end else if (!stall && d_mult) begin
      md_cnt <= MULT_LOAD;
    end else if (!stall && d_div) begin
      md_cnt <= DIV_LOAD;
    end else if (md_cnt != '0) begin
      md_cnt <= md_cnt - CNT_ONE;
    end
  end

endmodule

// File: tb/tb_hazard_ctrl.sv
// Scoreboard bench for hazard_ctrl: two instances (default and short-mult/long-div)
// share one instruction stream and are checked against a timeline model.
module tb_hazard_ctrl;

  typedef enum int {
    K_NOP, K_ADDU, K_SUBU, K_AND, K_OR, K_SLT, K_SLL, K_JR, K_JALR, K_MFHI, K_MFLO,
    K_MTHI, K_MTLO, K_MULT, K_MULTU, K_DIV, K_DIVU, K_BEQ, K_BNE, K_BLEZ, K_BGTZ,
    K_BLTZ, K_BGEZ, K_J, K_JAL, K_ADDIU, K_ORI, K_LUI, K_LW, K_LB, K_SW, K_SB, K_UNK,
    K_COUNT
  } kind_e;

  typedef struct {
    int aReg; int aUse; int bReg; int bUse;
    int dest; int tnew; bit md; int load;
  } info_t;

  typedef struct {
    int cyc;
    logic stall; logic [1:0] cause; logic busy;
    logic [4:0] eDest; logic [1:0] eTnew; logic [4:0] mDest; logic [1:0] mTnew;
  } obs_t;

  logic        clk, rst_n, valid_d;
  logic [31:0] instr_d;
  logic        stall0, busy0, stall1, busy1;
  logic [1:0]  cause0, eTnew0, mTnew0, cause1, eTnew1, mTnew1;
  logic [4:0]  eDest0, mDest0, eDest1, mDest1;

  obs_t sb0[$];
  obs_t sb1[$];
  int   nChecks = 0;
  int   nPass   = 0;
  int   cyc     = 0;
  bit   lastStall;

  // Result timeline per instance: absolute cycle at which the E/M result becomes forwardable.
  int eDest[2], eReady[2], mDest[2], mReady[2], mdUntil[2];
  int multN[2] = '{5, 1};
  int divN[2]  = '{10, 15};

  hazard_ctrl dut0 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .stall(stall0), .stall_cause(cause0), .md_busy(busy0),
    .e_dest(eDest0), .m_dest(mDest0), .e_tnew(eTnew0), .m_tnew(mTnew0)
  );

  hazard_ctrl #(.MULT_CYCLES(1), .DIV_CYCLES(15), .CNT_W(4)) dut1 (
    .clk(clk), .rst_n(rst_n), .instr_d(instr_d), .valid_d(valid_d),
    .stall(stall1), .stall_cause(cause1), .md_busy(busy1),
    .e_dest(eDest1), .m_dest(mDest1), .e_tnew(eTnew1), .m_tnew(mTnew1)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  function automatic logic [31:0] encode(kind_e k, logic [4:0] rs, logic [4:0] rt,
                                         logic [4:0] rd, logic [15:0] imm);
    logic [31:0] w;
    w = 32'd0;
    case (k)
      K_ADDU:  w = {6'h00, rs, rt, rd, 5'd0, 6'h21};
      K_SUBU:  w = {6'h00, rs, rt, rd, 5'd0, 6'h23};
      K_AND:   w = {6'h00, rs, rt, rd, 5'd0, 6'h24};
      K_OR:    w = {6'h00, rs, rt, rd, 5'd0, 6'h25};
      K_SLT:   w = {6'h00, rs, rt, rd, 5'd0, 6'h2a};
      K_SLL:   w = {6'h00, 5'd0, rt, rd, imm[4:1], 1'b1, 6'h00};
      K_JR:    w = {6'h00, rs, 15'd0, 6'h08};
      K_JALR:  w = {6'h00, rs, 5'd0, rd, 5'd0, 6'h09};
      K_MFHI:  w = {6'h00, 10'd0, rd, 5'd0, 6'h10};
      K_MFLO:  w = {6'h00, 10'd0, rd, 5'd0, 6'h12};
      K_MTHI:  w = {6'h00, rs, 15'd0, 6'h11};
      K_MTLO:  w = {6'h00, rs, 15'd0, 6'h13};
      K_MULT:  w = {6'h00, rs, rt, 10'd0, 6'h18};
      K_MULTU: w = {6'h00, rs, rt, 10'd0, 6'h19};
      K_DIV:   w = {6'h00, rs, rt, 10'd0, 6'h1a};
      K_DIVU:  w = {6'h00, rs, rt, 10'd0, 6'h1b};
      K_BEQ:   w = {6'h04, rs, rt, imm};
      K_BNE:   w = {6'h05, rs, rt, imm};
      K_BLEZ:  w = {6'h06, rs, 5'd0, imm};
      K_BGTZ:  w = {6'h07, rs, 5'd0, imm};
      K_BLTZ:  w = {6'h01, rs, 5'd0, imm};
      K_BGEZ:  w = {6'h01, rs, 5'd1, imm};
      K_J:     w = {6'h02, rs, rt, imm};
      K_JAL:   w = {6'h03, rs, rt, imm};
      K_ADDIU: w = {6'h09, rs, rt, imm};
      K_ORI:   w = {6'h0d, rs, rt, imm};
      K_LUI:   w = {6'h0f, 5'd0, rt, imm};
      K_LW:    w = {6'h23, rs, rt, imm};
      K_LB:    w = {6'h20, rs, rt, imm};
      K_SW:    w = {6'h2b, rs, rt, imm};
      K_SB:    w = {6'h28, rs, rt, imm};
      K_UNK:   w = {6'h3f, rs, rt, imm};
      default: w = 32'd0;
    endcase
    return w;
  endfunction

  // What each mnemonic reads (register, use time) and writes (register, Tnew at E entry).
  function automatic info_t classify(kind_e k, int rs, int rt, int rd);
    info_t f;
    f.aReg = 0; f.aUse = 0; f.bReg = 0; f.bUse = 0;
    f.dest = 0; f.tnew = 0; f.md = 1'b0; f.load = 0;
    case (k)
      K_ADDU, K_SUBU, K_AND, K_OR, K_SLT: begin
        f.aReg = rs; f.aUse = 1; f.bReg = rt; f.bUse = 1; f.dest = rd; f.tnew = 1;
      end
      K_SLL:  begin f.bReg = rt; f.bUse = 1; f.dest = rd; f.tnew = 1; end
      K_JR:   f.aReg = rs;
      K_JALR: begin f.aReg = rs; f.dest = rd; end
      K_MFHI, K_MFLO: begin f.dest = rd; f.tnew = 1; f.md = 1'b1; end
      K_MTHI, K_MTLO: begin f.aReg = rs; f.aUse = 1; f.md = 1'b1; end
      K_MULT, K_MULTU: begin
        f.aReg = rs; f.aUse = 1; f.bReg = rt; f.bUse = 1; f.md = 1'b1; f.load = 1;
      end
      K_DIV, K_DIVU: begin
        f.aReg = rs; f.aUse = 1; f.bReg = rt; f.bUse = 1; f.md = 1'b1; f.load = 2;
      end
      K_BEQ, K_BNE: begin f.aReg = rs; f.bReg = rt; end
      K_BLEZ, K_BGTZ, K_BLTZ, K_BGEZ: f.aReg = rs;
      K_JAL: f.dest = 31;
      K_ADDIU, K_ORI: begin f.aReg = rs; f.aUse = 1; f.dest = rt; f.tnew = 1; end
      K_LUI: begin f.dest = rt; f.tnew = 1; end
      K_LW, K_LB: begin f.aReg = rs; f.aUse = 1; f.dest = rt; f.tnew = 2; end
      K_SW, K_SB: begin f.aReg = rs; f.aUse = 1; f.bReg = rt; f.bUse = 2; end
      default: ;
    endcase
    return f;
  endfunction

  function automatic int remaining(int ready);
    return (ready > cyc) ? ready - cyc : 0;
  endfunction

  function automatic bit conflicts(int i, int r, int tuse);
    if (r == 0) return 1'b0;
    return (r == eDest[i] && remaining(eReady[i]) > tuse) ||
           (r == mDest[i] && remaining(mReady[i]) > tuse);
  endfunction

  task automatic modelReset(int i);
    eDest[i] = 0; eReady[i] = 0; mDest[i] = 0; mReady[i] = 0; mdUntil[i] = 0;
  endtask

  task automatic modelCycle(int i, info_t f, output obs_t o);
    bit haz, busy, mdh, stl;
    haz  = conflicts(i, f.aReg, f.aUse) || conflicts(i, f.bReg, f.bUse);
    busy = cyc < mdUntil[i];
    mdh  = f.md && busy;
    stl  = haz || mdh;
    o.cyc   = cyc;
    o.stall = stl;
    o.cause = haz ? 2'd1 : (mdh ? 2'd2 : 2'd0);
    o.busy  = busy;
    o.eDest = 5'(eDest[i]);
    o.eTnew = 2'(remaining(eReady[i]));
    o.mDest = 5'(mDest[i]);
    o.mTnew = 2'(remaining(mReady[i]));
    mDest[i]  = eDest[i];
    mReady[i] = eReady[i];
    eDest[i]  = stl ? 0 : f.dest;
    eReady[i] = cyc + 1 + (stl ? 0 : f.tnew);
    if (!stl && f.load == 1) mdUntil[i] = cyc + 1 + multN[i];
    else if (!stl && f.load == 2) mdUntil[i] = cyc + 1 + divN[i];
  endtask

  task automatic checkOutput(input string name, input int act, input int exp, input int at);
    nChecks++;
    if (act == exp) nPass++;
    else $display("[TB] FAIL %s cycle %0d: got %0d, expected %0d", name, at, act, exp);
  endtask

  task automatic compareObs(input int idx, input obs_t e, input obs_t a);
    string p;
    p = $sformatf("dut%0d.", idx);
    checkOutput({p, "stall"},       int'(a.stall), int'(e.stall), e.cyc);
    checkOutput({p, "stall_cause"}, int'(a.cause), int'(e.cause), e.cyc);
    checkOutput({p, "md_busy"},     int'(a.busy),  int'(e.busy),  e.cyc);
    checkOutput({p, "e_dest"},      int'(a.eDest), int'(e.eDest), e.cyc);
    checkOutput({p, "e_tnew"},      int'(a.eTnew), int'(e.eTnew), e.cyc);
    checkOutput({p, "m_dest"},      int'(a.mDest), int'(e.mDest), e.cyc);
    checkOutput({p, "m_tnew"},      int'(a.mTnew), int'(e.mTnew), e.cyc);
  endtask

  // Drive one cycle of D (or hold reset) and queue what both instances should show.
  task automatic applyStimulus(input kind_e k, input int rs, input int rt, input int rd,
                               input logic v, input logic resetLow);
    info_t f;
    obs_t  o;
    @(posedge clk);
    #1;
    rst_n   = !resetLow;
    instr_d = resetLow ? 32'd0 : encode(k, 5'(rs), 5'(rt), 5'(rd), 16'($urandom));
    valid_d = resetLow ? 1'b0 : v;
    for (int i = 0; i < 2; i++) begin
      if (resetLow) begin
        modelReset(i);
        o.cyc = cyc; o.stall = 1'b0; o.cause = 2'd0; o.busy = 1'b0;
        o.eDest = 5'd0; o.eTnew = 2'd0; o.mDest = 5'd0; o.mTnew = 2'd0;
      end else begin
        f = v ? classify(k, rs, rt, rd) : classify(K_NOP, 0, 0, 0);
        modelCycle(i, f, o);
      end
      if (i == 0) begin
        sb0.push_back(o);
        lastStall = o.stall;
      end else begin
        sb1.push_back(o);
      end
    end
    cyc++;
  endtask

  // Hold an instruction in D until the default instance lets it through.
  task automatic issue(input kind_e k, input int rs, input int rt, input int rd, input logic v);
    int n;
    n = 0;
    do begin
      applyStimulus(k, rs, rt, rd, v, 1'b0);
      n++;
    end while (lastStall && n < 40);
    if (lastStall) begin
      nChecks++;
      $display("[TB] FAIL issue_bound cycle %0d: still stalled after %0d cycles, expected issue", cyc, n);
    end
  endtask

  function automatic int pickReg();
    int r;
    r = $urandom_range(0, 9);
    return (r == 9) ? 31 : r;
  endfunction

  initial begin : monitor
    obs_t e, a;
    forever begin
      @(negedge clk);
      if (sb0.size() > 0) begin
        e = sb0.pop_front();
        a.cyc = e.cyc; a.stall = stall0; a.cause = cause0; a.busy = busy0;
        a.eDest = eDest0; a.eTnew = eTnew0; a.mDest = mDest0; a.mTnew = mTnew0;
        compareObs(0, e, a);
      end
      if (sb1.size() > 0) begin
        e = sb1.pop_front();
        a.cyc = e.cyc; a.stall = stall1; a.cause = cause1; a.busy = busy1;
        a.eDest = eDest1; a.eTnew = eTnew1; a.mDest = mDest1; a.mTnew = mTnew1;
        compareObs(1, e, a);
      end
    end
  end

  initial begin : stimulus
    kind_e k;
    rst_n   = 1'b0;
    instr_d = 32'd0;
    valid_d = 1'b0;
    for (int i = 0; i < 2; i++) modelReset(i);
    repeat (2) applyStimulus(K_NOP, 0, 0, 0, 1'b0, 1'b1);

    // Load-use, then branch after ALU and after load.
    issue(K_LW, 1, 2, 0, 1'b1);
    issue(K_ADDU, 2, 4, 3, 1'b1);
    issue(K_NOP, 0, 0, 0, 1'b1);
    issue(K_ADDU, 6, 7, 5, 1'b1);
    issue(K_BEQ, 5, 0, 0, 1'b1);
    issue(K_LW, 1, 5, 0, 1'b1);
    issue(K_BEQ, 5, 0, 0, 1'b1);
    // jal/jr, writes to $0, load feeding store data.
    issue(K_JAL, 0, 0, 0, 1'b1);
    issue(K_JR, 31, 0, 0, 1'b1);
    issue(K_LW, 1, 0, 0, 1'b1);
    issue(K_ADDU, 0, 0, 3, 1'b1);
    issue(K_LW, 1, 8, 0, 1'b1);
    issue(K_SW, 9, 8, 0, 1'b1);
    // Multiply/divide busy windows.
    issue(K_MULT, 1, 2, 0, 1'b1);
    issue(K_MFLO, 0, 0, 3, 1'b1);
    issue(K_DIV, 1, 2, 0, 1'b1);
    issue(K_MFLO, 0, 0, 3, 1'b1);
    issue(K_MULT, 1, 2, 0, 1'b1);
    issue(K_MTHI, 1, 0, 0, 1'b1);
    repeat (16) issue(K_NOP, 0, 0, 0, 1'b1);
    // Reset three cycles into a divide, then mfhi must go straight through.
    issue(K_DIV, 3, 4, 0, 1'b1);
    issue(K_NOP, 0, 0, 0, 1'b1);
    issue(K_NOP, 0, 0, 0, 1'b1);
    applyStimulus(K_NOP, 0, 0, 0, 1'b0, 1'b1);
    issue(K_MFHI, 0, 0, 4, 1'b1);
    repeat (16) issue(K_NOP, 0, 0, 0, 1'b1);

    for (int n = 0; n < 900; n++) begin
      if ($urandom_range(0, 150) == 0) begin
        repeat (2) applyStimulus(K_NOP, 0, 0, 0, 1'b0, 1'b1);
      end
      k = kind_e'($urandom_range(0, int'(K_COUNT) - 1));
      issue(k, pickReg(), pickReg(), pickReg(), ($urandom_range(0, 9) != 0));
    end

    @(negedge clk);
    #1;
    checkOutput("sb0_drained", sb0.size(), 0, cyc);
    checkOutput("sb1_drained", sb1.size(), 0, cyc);
    $display("%0d/%0d checks passed", nPass, nChecks);
    $finish;
  end

endmodule
